// File: rtl/pong_pkg.sv
// Shared state encodings, limits and BCD helper for the Pong game-flow controller.
package pong_pkg;

    typedef logic [1:0] game_state_t;

    localparam game_state_t ST_NEWGAME = 2'd0;
    localparam game_state_t ST_PLAY    = 2'd1;
    localparam game_state_t ST_NEWBALL = 2'd2;
    localparam game_state_t ST_OVER    = 2'd3;

    localparam logic [7:0] BCD_MAX = 8'h99;

    localparam int unsigned TIMER_FRAMES_DEF = 120;
    localparam int unsigned BALLS_INIT_DEF   = 3;

    // Two-digit BCD increment that sticks at BCD_MAX instead of wrapping.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v >= BCD_MAX) begin
            r = BCD_MAX;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Bundle between VGA sync / graphics / text overlay and the game-flow controller.
interface pong_game_ctrl_if;
    import pong_pkg::*;

    logic [9:0]  x;
    logic [9:0]  y;
    logic [1:0]  btn;
    logic        hit;
    logic        miss;
    logic        gra_still;
    game_state_t game_state;
    logic [7:0]  score;
    logic [1:0]  balls_left;
    logic [7:0]  hi_score;

    modport master (
        output x, y, btn, hit, miss,
        input  gra_still, game_state, score, balls_left, hi_score
    );

    modport slave (
        input  x, y, btn, hit, miss,
        output gra_still, game_state, score, balls_left, hi_score
    );

endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter with synchronous clear, increment and saturation at 99.
module bcd2_counter
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'h00;
        end else if (inc) begin
            count_d = bcd_inc(count_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 8'h00;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow FSM: frame tick, dwell timer, score and ball bookkeeping.
// Define PONG_HIGH_SCORE_EN to keep a high-score register across games.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned TIMER_FRAMES = TIMER_FRAMES_DEF,
    parameter int unsigned BALLS_INIT   = BALLS_INIT_DEF,
    parameter int unsigned TICK_Y       = 481
) (
    input logic             clk,
    input logic             reset,
    pong_game_ctrl_if.slave bus
);

    localparam logic [9:0] TICK_ROW   = TICK_Y[9:0];
    localparam logic [6:0] TIMER_LOAD = TIMER_FRAMES[6:0];
    localparam logic [1:0] BALLS_LOAD = BALLS_INIT[1:0];

    game_state_t state_q, state_d;
    logic [6:0]  timer_q, timer_d;
    logic [1:0]  balls_q, balls_d;
    logic        tick_q;
    logic        hit_q;
    logic        tick_cond;
    logic        ftick;
    logic        hit_rise;
    logic        timer_up;
    logic        score_inc;
    logic        score_clr;
    logic        enter_over;
    logic [7:0]  score;

    // The raw row/column match lasts a whole pixel; keep only its first clock.
    assign tick_cond = (bus.y == TICK_ROW) && (bus.x == 10'd0);
    assign ftick     = tick_cond & ~tick_q;
    assign hit_rise  = bus.hit & ~hit_q;
    assign timer_up  = (timer_q == 7'd0);

    always_comb begin
        state_d   = state_q;
        balls_d   = balls_q;
        score_inc = 1'b0;
        score_clr = 1'b0;
        case (state_q)
            ST_NEWGAME: begin
                if (bus.btn != 2'b00) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A miss takes priority over a simultaneous hit.
                if (bus.miss) begin
                    if (balls_q != 2'd0) begin
                        balls_d = balls_q - 2'd1;
                    end
                    state_d = (balls_q <= 2'd1) ? ST_OVER : ST_NEWBALL;
                end else if (hit_rise) begin
                    score_inc = 1'b1;
                end
            end
            ST_NEWBALL: begin
                if (timer_up && (bus.btn != 2'b00)) begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (timer_up) begin
                    state_d   = ST_NEWGAME;
                    score_clr = 1'b1;
                    balls_d   = BALLS_LOAD;
                end
            end
            default: begin
                state_d = ST_NEWGAME;
            end
        endcase
    end

    // Reload on entry to a waiting state, otherwise count frames down to zero.
    always_comb begin
        timer_d = timer_q;
        if ((state_d != state_q) && ((state_d == ST_NEWBALL) || (state_d == ST_OVER))) begin
            timer_d = TIMER_LOAD;
        end else if (ftick && !timer_up) begin
            timer_d = timer_q - 7'd1;
        end
    end

    assign enter_over = (state_d == ST_OVER) && (state_q != ST_OVER);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_NEWGAME;
            timer_q <= 7'd0;
            balls_q <= BALLS_LOAD;
            tick_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            balls_q <= balls_d;
            tick_q  <= tick_cond;
            hit_q   <= bus.hit;
        end
    end

    bcd2_counter u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .count (score)
    );

`ifdef PONG_HIGH_SCORE_EN
    logic [7:0] hi_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= 8'h00;
        end else if (enter_over && (score > hi_q)) begin
            hi_q <= score;
        end
    end

    assign bus.hi_score = hi_q;
`else
    logic unused_enter_over;
    assign unused_enter_over = enter_over;
    assign bus.hi_score      = 8'h00;
`endif

    assign bus.gra_still  = (state_q != ST_PLAY);
    assign bus.game_state = state_q;
    assign bus.score      = score;
    assign bus.balls_left = balls_q;

endmodule
